sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in / parallel-out receiver. It is the receive end of the serial stream produced by the team's parallel-in serial-out shift register.
- Shifts in qualified serial bits and counts them into WIDTH-bit words.
- Transfers each completed word into a holding register, which it presents to downstream logic over a valid/ready handshake.
- Flags overrun and framing errors. Includes a clock-inhibit freeze, as on the transmit side.

Parameters:
- WIDTH, 8, word length in bits (≥2).
- MSB_FIRST, 1, 1 means the first received bit lands in bit WIDTH-1; 0 means the first received bit lands in bit 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_inh  input  1  when high, freezes the shift register and bit counter.
- ser  input  1  serial data bit.
- ser_valid  input  1  ser is sampled on this edge.
- frame_start  input  1  with ser_valid, marks ser as bit 0 of a new word.
- q  output  WIDTH  live shift-register contents.
- bit_cnt  output  $clog2(WIDTH)  bits collected in the current word.
- par_out  output  WIDTH  holding register (completed word).
- par_valid  output  1  par_out holds an unconsumed word.
- par_ready  input  1  downstream accepts par_out.
- err_clr  input  1  clears overrun and frame_err.
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: a partial word was aborted by frame_start.

Behaviour:
- Reset (async, rst_n=0): q=0, bit_cnt=0, par_out=0, par_valid=0, overrun=0, frame_err=0, FSM=IDLE. Reset mid-word discards the partial word. No output changes until the first edge after rst_n rises.
- Accept condition: acc = ser_valid & ~clk_inh.
- clk_inh=1 effects: q and bit_cnt hold and ser is ignored. The handshake side (par_valid/par_ready) and err_clr still operate.
- Shift direction:
  - MSB_FIRST=1: q <= {q[WIDTH-2:0], ser}.
  - MSB_FIRST=0: q <= {ser, q[WIDTH-1:1]}.
- FSM states:
  - IDLE (bit_cnt=0).
  - RECV (0<bit_cnt<WIDTH).
- Transitions:
  - IDLE + acc → RECV, bit_cnt=1.
  - RECV + acc with bit_cnt<WIDTH-1 → bit_cnt+1.
  - RECV + acc with bit_cnt=WIDTH-1 → word complete, bit_cnt wraps to 0, → IDLE.
  - acc & frame_start → bit_cnt=1 and ser becomes the first bit of a new word. If this occurs in RECV, set frame_err. In IDLE, frame_start is legal and raises no error.
- Word completion, on the edge sampling bit WIDTH-1: the completed word is the shifted value including ser. One-cycle latency: par_out and par_valid are visible after that edge.
  - If par_valid=0, or par_valid=1 and par_ready=1 on the same edge: par_out <= word, par_valid stays/goes 1.
  - If par_valid=1 and par_ready=0: the word is dropped, par_out is unchanged, overrun <= 1.
- Handshake:
  - Transfer occurs on an edge where par_valid & par_ready.
  - par_valid clears after a transfer unless a word completes on that same edge.
  - par_ready while par_valid=0 has no effect.
  - par_out is stable while par_valid=1 and par_ready=0.
- Errors:
  - overrun and frame_err are sticky; err_clr clears both on the next edge.
  - If err_clr coincides with a new error event, the error wins (flag stays 1).
- q is observable every cycle. q is not cleared on word completion; the next word shifts over it.

Test Plan:
- MSB_FIRST=1:
  - Reset, then shift 1,0,1,1,0,1,1,0 with ser_valid=1 and par_ready=0 → after 8th edge: par_out=8'hB6, par_valid=1, bit_cnt=0, q=8'hB6.
  - Then par_ready=1 for one cycle → par_valid=0 next cycle.
- Inhibit: after 3 bits (q=8'h05 for 1,0,1), clk_inh=1, ser=1, ser_valid=1 for 2 cycles → q=8'h05, bit_cnt=3 unchanged. Release clk_inh and shift 5 more 1s → par_out=8'hBF.
- Overrun:
  - Complete 8'hB6, hold par_ready=0, complete 8'h3C → par_out=8'hB6, overrun=1.
  - err_clr pulse → overrun=0.
  - Repeat with par_ready=1 on the completion edge of the 2nd word → par_out=8'h3C, par_valid=1, overrun=0.
- Framing: 4 bits in, then frame_start with ser_valid → frame_err=1, bit_cnt=1. Send 7 more bits of 8'hA5 (first bit was its MSB) → par_out=8'hA5.
- Reset mid-operation: 5 bits in and par_valid=1, assert rst_n=0 between edges → q, bit_cnt, par_out, par_valid, and both error flags read 0 immediately (before the next clk edge).
- MSB_FIRST=0: shift 0,1,1,0,1,1,0,1 (8'hB6 LSB-first) → par_out=8'hB6.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out link: qualified serial stream in, valid/ready word out.
// master is the stream source plus word sink; slave is the deserializer.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ser;
    logic             ser_valid;
    logic             frame_start;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             par_ready;

    modport master (
        output ser,
        output ser_valid,
        output frame_start,
        output par_ready,
        input  par_out,
        input  par_valid
    );

    modport slave (
        input  ser,
        input  ser_valid,
        input  frame_start,
        input  par_ready,
        output par_out,
        output par_valid
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out receiver: shifts qualified bits into WIDTH-bit words and
// hands each completed word to downstream over valid/ready, flagging overrun and framing errors.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_inh,
    input  logic                     err_clr,
    sipo_deserializer_if.slave       bus,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun,
    output logic                     frame_err
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_n;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] q_n;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] par_out_r;
    logic [WIDTH-1:0] par_out_n;
    logic             par_valid_r;
    logic             par_valid_n;
    logic             overrun_n;
    logic             frame_err_n;
    logic             acc;
    logic             word_done;
    logic             ovr_evt;
    logic             ferr_evt;

    // Shift register value after taking in the current serial bit.
    if (MSB_FIRST) begin : g_msb_first
        assign shifted = {q[WIDTH-2:0], bus.ser};
    end else begin : g_lsb_first
        assign shifted = {bus.ser, q[WIDTH-1:1]};
    end

    assign bus.par_out   = par_out_r;
    assign bus.par_valid = par_valid_r;

    // State, shift register, holding register and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q           <= '0;
            bit_cnt     <= '0;
            par_out_r   <= '0;
            par_valid_r <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            q           <= q_n;
            bit_cnt     <= cnt_n;
            par_out_r   <= par_out_n;
            par_valid_r <= par_valid_n;
            overrun     <= overrun_n;
            frame_err   <= frame_err_n;
        end
    end

    // Next-state: bit collection, word hand-off and sticky error flags.
    always_comb begin
        state_n     = state;
        q_n         = q;
        cnt_n       = bit_cnt;
        par_out_n   = par_out_r;
        par_valid_n = par_valid_r;
        word_done   = 1'b0;
        ovr_evt     = 1'b0;
        ferr_evt    = 1'b0;
        acc         = bus.ser_valid & ~clk_inh;

        if (acc) begin
            q_n = shifted;
            if (bus.frame_start) begin
                // Restart the word on this bit; aborting a partial word is an error.
                state_n  = RECV;
                cnt_n    = CW'(1);
                ferr_evt = (state == RECV);
            end else if (state == IDLE) begin
                state_n = RECV;
                cnt_n   = CW'(1);
            end else if (bit_cnt == CNT_LAST) begin
                state_n   = IDLE;
                cnt_n     = '0;
                word_done = 1'b1;
            end else begin
                cnt_n = bit_cnt + CW'(1);
            end
        end

        if (par_valid_r && bus.par_ready) begin
            par_valid_n = 1'b0;
        end

        // A new word may replace the held one only if the held one leaves on this edge.
        if (word_done) begin
            if (!par_valid_r || bus.par_ready) begin
                par_out_n   = shifted;
                par_valid_n = 1'b1;
            end else begin
                ovr_evt = 1'b1;
            end
        end

        overrun_n   = ovr_evt  | (overrun   & ~err_clr);
        frame_err_n = ferr_evt | (frame_err & ~err_clr);
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: table vectors, hand-written corner sequences and
// randomized traffic against a word-level reference model, on MSB-first and LSB-first builds.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic rst_n;
    logic ser, sv, fs, inh, rdy, eclr;

    logic [7:0] q_m, q_l;
    logic [2:0] cnt_m, cnt_l;
    logic       ovr_m, ovr_l, ferr_m, ferr_l;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(8)) if_m ();
    sipo_deserializer_if #(.WIDTH(8)) if_l ();

    assign if_m.ser = ser;  assign if_m.ser_valid = sv;  assign if_m.frame_start = fs;  assign if_m.par_ready = rdy;
    assign if_l.ser = ser;  assign if_l.ser_valid = sv;  assign if_l.frame_start = fs;  assign if_l.par_ready = rdy;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .clk_inh(inh), .err_clr(eclr), .bus(if_m),
        .q(q_m), .bit_cnt(cnt_m), .overrun(ovr_m), .frame_err(ferr_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .clk_inh(inh), .err_clr(eclr), .bus(if_l),
        .q(q_l), .bit_cnt(cnt_l), .overrun(ovr_l), .frame_err(ferr_l)
    );

    typedef struct {
        bit         rst;
        bit         ser, sv, fs, inh, rdy, eclr;
        logic [7:0] q;
        logic [2:0] cnt;
        logic [7:0] par;
        bit         pv, ovr, ferr;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit s, input bit v, input bit f, input bit i,
                                input bit rd, input bit e, input logic [7:0] eq, input logic [2:0] ec,
                                input logic [7:0] ep, input bit epv, input bit eo, input bit ef);
        vec_t t;
        t.rst = r; t.ser = s; t.sv = v; t.fs = f; t.inh = i; t.rdy = rd; t.eclr = e;
        t.q = eq; t.cnt = ec; t.par = ep; t.pv = epv; t.ovr = eo; t.ferr = ef;
        tbl.push_back(t);
    endfunction

    // 8'hB6 straight after reset, par_ready low throughout.
    function automatic void add_b6();
        add(1, 1,1,0,0,0,0, 8'h01, 3'd1, 8'h00, 0, 0, 0);
        add(0, 0,1,0,0,0,0, 8'h02, 3'd2, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h05, 3'd3, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h0B, 3'd4, 8'h00, 0, 0, 0);
        add(0, 0,1,0,0,0,0, 8'h16, 3'd5, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h2D, 3'd6, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h5B, 3'd7, 8'h00, 0, 0, 0);
        add(0, 0,1,0,0,0,0, 8'hB6, 3'd0, 8'hB6, 1, 0, 0);
    endfunction

    // 8'h3C following a held 8'hB6; par_ready only on the completing edge when last_rdy.
    function automatic void add_3c(input bit last_rdy);
        add(0, 0,1,0,0,0,0, 8'h6C, 3'd1, 8'hB6, 1, 0, 0);
        add(0, 0,1,0,0,0,0, 8'hD8, 3'd2, 8'hB6, 1, 0, 0);
        add(0, 1,1,0,0,0,0, 8'hB1, 3'd3, 8'hB6, 1, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h63, 3'd4, 8'hB6, 1, 0, 0);
        add(0, 1,1,0,0,0,0, 8'hC7, 3'd5, 8'hB6, 1, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h8F, 3'd6, 8'hB6, 1, 0, 0);
        add(0, 0,1,0,0,0,0, 8'h1E, 3'd7, 8'hB6, 1, 0, 0);
        if (last_rdy) add(0, 0,1,0,0,1,0, 8'h3C, 3'd0, 8'h3C, 1, 0, 0);
        else          add(0, 0,1,0,0,0,0, 8'h3C, 3'd0, 8'hB6, 1, 1, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input bit lsb, input logic [7:0] eq, input logic [2:0] ec,
                             input logic [7:0] ep, input bit epv, input bit eo, input bit ef);
        chk({tag, ".q"},         32'(lsb ? q_l : q_m),                 32'(eq));
        chk({tag, ".bit_cnt"},   32'(lsb ? cnt_l : cnt_m),             32'(ec));
        chk({tag, ".par_out"},   32'(lsb ? if_l.par_out : if_m.par_out), 32'(ep));
        chk({tag, ".par_valid"}, 32'(lsb ? if_l.par_valid : if_m.par_valid), 32'(epv));
        chk({tag, ".overrun"},   32'(lsb ? ovr_l : ovr_m),             32'(eo));
        chk({tag, ".frame_err"}, 32'(lsb ? ferr_l : ferr_m),           32'(ef));
    endtask

    task automatic do_reset();
        ser = 0; sv = 0; fs = 0; inh = 0; rdy = 0; eclr = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic cyc(input bit s, input bit v, input bit f, input bit i, input bit rd, input bit e);
        ser = s; sv = v; fs = f; inh = i; rdy = rd; eclr = e;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n);
        logic [7:0] b;
        b = bits;
        for (int k = n - 1; k >= 0; k--) cyc(b[k], 1, 0, 0, 0, 0);
    endtask

    // Reference model: words are lists of accepted bits; q is the last eight bits as a number.
    bit cur[$];
    int m_qm, m_ql, m_parm, m_parl, m_pv, m_ovr, m_ferr;

    function automatic void model_reset();
        cur.delete();
        m_qm = 0; m_ql = 0; m_parm = 0; m_parl = 0; m_pv = 0; m_ovr = 0; m_ferr = 0;
    endfunction

    function automatic void model_step(input bit s, input bit v, input bit f, input bit i,
                                       input bit rd, input bit e);
        bit done, new_ovr, new_ferr;
        int wm, wl;
        done = 0; new_ovr = 0; new_ferr = 0; wm = 0; wl = 0;
        if (v && !i) begin
            m_qm = (m_qm * 2 + int'(s)) % 256;
            m_ql = m_ql / 2 + int'(s) * 128;
            if (f) begin
                if (cur.size() > 0) new_ferr = 1;
                cur.delete();
                cur.push_back(s);
            end else begin
                cur.push_back(s);
                if (cur.size() == 8) begin
                    for (int k = 0; k < 8; k++) begin
                        wm += int'(cur[k]) * (1 << (7 - k));
                        wl += int'(cur[k]) * (1 << k);
                    end
                    done = 1;
                    cur.delete();
                end
            end
        end
        if (done && (m_pv == 0 || rd)) begin
            m_parm = wm; m_parl = wl; m_pv = 1;
        end else begin
            if (done) new_ovr = 1;
            if (m_pv == 1 && rd) m_pv = 0;
        end
        m_ovr  = new_ovr  ? 1 : (e ? 0 : m_ovr);
        m_ferr = new_ferr ? 1 : (e ? 0 : m_ferr);
    endfunction

    initial begin
        rst_n = 1'b1;
        do_reset();
        check_dut("reset", 0, 8'h00, 3'd0, 8'h00, 0, 0, 0);

        // Table: basic word + handshake, inhibit, overrun and its recovery, ready-on-completion.
        add_b6();
        add(0, 0,0,0,0,1,0, 8'hB6, 3'd0, 8'hB6, 0, 0, 0);
        add(1, 1,1,0,0,0,0, 8'h01, 3'd1, 8'h00, 0, 0, 0);
        add(0, 0,1,0,0,0,0, 8'h02, 3'd2, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h05, 3'd3, 8'h00, 0, 0, 0);
        add(0, 1,1,0,1,0,0, 8'h05, 3'd3, 8'h00, 0, 0, 0);
        add(0, 1,1,0,1,0,0, 8'h05, 3'd3, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h0B, 3'd4, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h17, 3'd5, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h2F, 3'd6, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'h5F, 3'd7, 8'h00, 0, 0, 0);
        add(0, 1,1,0,0,0,0, 8'hBF, 3'd0, 8'hBF, 1, 0, 0);
        add_b6();
        add_3c(1'b0);
        add(0, 0,0,0,0,0,1, 8'h3C, 3'd0, 8'hB6, 1, 0, 0);
        add_b6();
        add_3c(1'b1);

        foreach (tbl[k]) begin
            if (tbl[k].rst) do_reset();
            cyc(tbl[k].ser, tbl[k].sv, tbl[k].fs, tbl[k].inh, tbl[k].rdy, tbl[k].eclr);
            check_dut($sformatf("vec%0d", k), 0, tbl[k].q, tbl[k].cnt, tbl[k].par,
                      tbl[k].pv, tbl[k].ovr, tbl[k].ferr);
        end

        // Framing: frame_start in IDLE is legal; in RECV it aborts the word and flags.
        do_reset();
        cyc(1, 1, 1, 0, 0, 0);
        chk("fs_idle.frame_err", 32'(ferr_m), 32'(0));
        chk("fs_idle.bit_cnt",   32'(cnt_m),  32'(1));
        send_bits(8'h07, 3);
        cyc(1, 1, 1, 0, 0, 0);
        chk("fs_recv.frame_err", 32'(ferr_m), 32'(1));
        chk("fs_recv.bit_cnt",   32'(cnt_m),  32'(1));
        send_bits(8'h25, 7);
        check_dut("fs_a5", 0, 8'hA5, 3'd0, 8'hA5, 1, 0, 1);
        send_bits(8'h07, 3);
        cyc(0, 1, 1, 0, 1, 1);
        chk("fs_clr_race.frame_err", 32'(ferr_m), 32'(1));
        cyc(0, 0, 0, 0, 0, 1);
        chk("err_clr.frame_err", 32'(ferr_m), 32'(0));

        // Asynchronous reset mid-word with a held word and a pending framing error.
        do_reset();
        send_bits(8'hB6, 8);
        send_bits(8'h15, 5);
        cyc(1, 1, 1, 0, 0, 0);
        chk("pre_rst.frame_err", 32'(ferr_m), 32'(1));
        chk("pre_rst.par_valid", 32'(if_m.par_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_dut("async_rst", 0, 8'h00, 3'd0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LSB-first build.
        do_reset();
        send_bits(8'h6D, 8);
        check_dut("lsb_b6", 1, 8'hB6, 3'd0, 8'hB6, 1, 0, 0);

        // Randomized traffic on both builds against the model.
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            bit s, v, f, i, rd, e;
            if (n == 300) begin
                do_reset();
                model_reset();
            end
            s  = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 3) != 0);
            f  = ($urandom_range(0, 19) == 0);
            i  = ($urandom_range(0, 6) == 0);
            rd = ($urandom_range(0, 2) == 0);
            e  = ($urandom_range(0, 15) == 0);
            model_step(s, v, f, i, rd, e);
            cyc(s, v, f, i, rd, e);
            check_dut($sformatf("rnd%0d.msb", n), 0, 8'(m_qm), 3'(cur.size()), 8'(m_parm),
                      m_pv != 0, m_ovr != 0, m_ferr != 0);
            check_dut($sformatf("rnd%0d.lsb", n), 1, 8'(m_ql), 3'(cur.size()), 8'(m_parl),
                      m_pv != 0, m_ovr != 0, m_ferr != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
